// File: rtl/pbs_pkg.sv
// Shared constants and helpers for the pbs_move_rng battle front end.
package pbs_pkg;

  // Width of a move index and of the damage/accuracy/roll values.
  localparam int unsigned MOVE_W  = 2;
  localparam int unsigned STAT_W  = 5;
  localparam int unsigned NUM_SRC = 6;
  localparam int unsigned LFSR_W  = 16;

  // Galois feedback mask, applied when the bit shifted out is 1.
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

  // Move table indexed by move number.
  localparam logic [STAT_W-1:0] MOVE_DMG  [0:3] = '{5'd2,  5'd4,  5'd6, 5'd9};
  localparam logic [STAT_W-1:0] MOVE_ACCU [0:3] = '{5'd16, 5'd12, 5'd8, 5'd4};

  // Seed of source idx. A zero seed would lock the LFSR, so it becomes 1.
  function automatic logic [LFSR_W-1:0] seed_of(input logic [LFSR_W-1:0] base,
                                                input int unsigned      idx);
    logic [LFSR_W-1:0] mult;
    logic [LFSR_W-1:0] seed;
    mult = LFSR_W'((idx + 32'd1) * 32'h0000_1111);
    seed = base ^ mult;
    if (seed == 16'h0000) begin
      seed = 16'h0001;
    end else begin
      seed = seed;
    end
    return seed;
  endfunction

  // One Galois step: shift right, fold in the polynomial on a 1 out.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    if (s[0]) begin
      n = (s >> 1) ^ LFSR_POLY;
    end else begin
      n = s >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/pbs_rand_bit.sv
// Freezable 16-bit Galois LFSR producing one pseudo-random bit.
module pbs_rand_bit
  import pbs_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic clk,
  input  logic rst,
  input  logic stop,
  output logic random
);

  // A zero state never leaves zero, so guard against it here as well.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [LFSR_W-1:0] state_d;
  logic [LFSR_W-1:0] state_q;

  // Next state: hold while frozen, otherwise advance one Galois step.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = state_q;
    end else begin
      state_d = lfsr_next(state_q);
    end
  end

  // State register; reset reloads the seed and wins over stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign random = state_q[0];

endmodule

// File: rtl/pbs_move_rng.sv
// Battle front end: random AI move and accuracy roll, registered move
// selection, and move-table lookup with hit decision.
module pbs_move_rng
  import pbs_pkg::*;
#(
  parameter logic [15:0] SEED_BASE = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop,
  input  logic [MOVE_W-1:0] p_move,
  input  logic              actr,
  output logic [MOVE_W-1:0] ai_move,
  output logic [STAT_W-1:0] accu_rng,
  output logic [MOVE_W-1:0] move_sel,
  output logic [STAT_W-1:0] dmg,
  output logic [STAT_W-1:0] accu,
  output logic              hit
);

  logic [NUM_SRC-1:0] src_s;
  logic [MOVE_W-1:0]  move_sel_d;
  logic [MOVE_W-1:0]  move_sel_q;

  // Six independent sources, each with its own derived seed.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    pbs_rand_bit #(
      .SEED(seed_of(SEED_BASE, g))
    ) u_rand_bit (
      .clk   (clk),
      .rst   (rst),
      .stop  (stop),
      .random(src_s[g])
    );
  end

  assign ai_move  = {src_s[1], src_s[0]};
  assign accu_rng = {1'b0, src_s[5], src_s[4], src_s[3], src_s[2]};

  // Pick the acting trainer's move; stop does not gate this path.
  always_comb begin
    move_sel_d = move_sel_q;
    if (actr) begin
      move_sel_d = ai_move;
    end else begin
      move_sel_d = p_move;
    end
  end

  // Move selection register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      move_sel_q <= 2'd0;
    end else begin
      move_sel_q <= move_sel_d;
    end
  end

  assign move_sel = move_sel_q;

  // Table lookup and hit compare; move 0 (accu 16) beats any roll 0..15.
  always_comb begin
    dmg  = MOVE_DMG[move_sel_q];
    accu = MOVE_ACCU[move_sel_q];
    if (accu >= accu_rng) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: tb/tb_pbs_move_rng.sv
// Scoreboard bench for pbs_move_rng: stimulus pushes expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_pbs_move_rng;

  logic       clk;
  logic       rst;
  logic       stop;
  logic [1:0] p_move;
  logic       actr;
  logic [1:0] ai_move;
  logic [4:0] accu_rng;
  logic [1:0] move_sel;
  logic [4:0] dmg;
  logic [4:0] accu;
  logic       hit;

  pbs_move_rng #(.SEED_BASE(16'hACE1)) dut (
    .clk     (clk),
    .rst     (rst),
    .stop    (stop),
    .p_move  (p_move),
    .actr    (actr),
    .ai_move (ai_move),
    .accu_rng(accu_rng),
    .move_sel(move_sel),
    .dmg     (dmg),
    .accu    (accu),
    .hit     (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: {ai_move, accu_rng, move_sel, dmg, accu, hit}
  typedef struct {
    string       name;
    logic [19:0] exp;
    logic [19:0] mask;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [15:0] m_s[6];
  logic [1:0]  m_sel;

  function automatic logic [19:0] pack(input logic [1:0] a, input logic [4:0] r,
                                       input logic [1:0] s, input logic [4:0] d,
                                       input logic [4:0] c, input logic h);
    return {a, r, s, d, c, h};
  endfunction

  function automatic logic [15:0] ref_seed(input int k);
    logic [15:0] sd;
    sd = 16'hACE1 ^ 16'((k + 1) * 32'h1111);
    if (sd == 16'h0000) sd = 16'h0001;
    return sd;
  endfunction

  function automatic logic [19:0] model_vec();
    logic [1:0] a;
    logic [4:0] r, d, c;
    a = {m_s[1][0], m_s[0][0]};
    r = {1'b0, m_s[5][0], m_s[4][0], m_s[3][0], m_s[2][0]};
    case (m_sel)
      2'd0: begin d = 5'd2; c = 5'd16; end
      2'd1: begin d = 5'd4; c = 5'd12; end
      2'd2: begin d = 5'd6; c = 5'd8;  end
      default: begin d = 5'd9; c = 5'd4; end
    endcase
    return pack(a, r, m_sel, d, c, (c >= r));
  endfunction

  task automatic push(input string nm, input logic [19:0] e, input logic [19:0] m);
    exp_t x;
    x.name = nm; x.exp = e; x.mask = m;
    sb.push_back(x);
  endtask

  // One clock with given inputs; advances the model and queues its view.
  task automatic step(input logic r, input logic s, input logic [1:0] p, input logic a);
    logic [15:0] n_s[6];
    logic [1:0]  n_sel;
    rst = r; stop = s; p_move = p; actr = a;
    for (int k = 0; k < 6; k++) begin
      if (r)      n_s[k] = ref_seed(k);
      else if (s) n_s[k] = m_s[k];
      else        n_s[k] = (m_s[k] >> 1) ^ (m_s[k][0] ? 16'hB400 : 16'h0000);
    end
    n_sel = r ? 2'd0 : (a ? {m_s[1][0], m_s[0][0]} : p);
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) m_s[k] = n_s[k];
    m_sel = n_sel;
    push("model", model_vec(), 20'hFFFFF);
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        logic [19:0] act;
        e   = sb.pop_front();
        act = {ai_move, accu_rng, move_sel, dmg, accu, hit};
        n_checks++;
        if ((act & e.mask) === (e.exp & e.mask)) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got %05h expected %05h (mask %05h) at %0t",
                   e.name, act, e.exp, e.mask, $time);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  localparam logic [19:0] V_RESET = 20'h0;

  initial begin
    logic [19:0] v_reset, v_p3, v_p1, v_ai;
    v_reset = pack(2'd2, 5'd10, 2'd0, 5'd2, 5'd16, 1'b1);
    v_p3    = pack(2'd2, 5'd10, 2'd3, 5'd9, 5'd4,  1'b0);
    v_p1    = pack(2'd2, 5'd10, 2'd1, 5'd4, 5'd12, 1'b1);
    v_ai    = pack(2'd2, 5'd10, 2'd2, 5'd6, 5'd8,  1'b0);
    for (int k = 0; k < 6; k++) m_s[k] = 16'h0000;
    m_sel = 2'd0;
    rst = 1'b1; stop = 1'b1; p_move = 2'd0; actr = 1'b0;

    // Reset, then player path while frozen
    step(1'b1, 1'b1, 2'd0, 1'b0); push("reset", v_reset, 20'hFFFFF);
    step(1'b0, 1'b1, 2'd3, 1'b0); push("player_move3", v_p3, 20'hFFFFF);
    step(1'b0, 1'b1, 2'd1, 1'b0); push("player_move1", v_p1, 20'hFFFFF);

    // AI path with freeze: repeated latches hold the same move
    step(1'b1, 1'b1, 2'd0, 1'b0); push("reset2", v_reset, 20'hFFFFF);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 2'd3, 1'b1); push("ai_frozen", v_ai, 20'hFFFFF);
    end

    // First LFSR step: source 0 goes BDF0 -> 5EF8, so ai_move[0] = 0
    step(1'b1, 1'b1, 2'd0, 1'b0); push("reset3", v_reset, 20'hFFFFF);
    step(1'b0, 1'b0, 2'd0, 1'b0); push("lfsr_step_src0", 20'h00000, 20'h40000);

    // Long free run against the model with varied move sources
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b0, 2'(i), 1'((i >> 2) & 1));
    end

    // Stop mid-run: 17 free, 5 frozen (AI latching), then continue
    step(1'b1, 1'b1, 2'd0, 1'b0); push("reset4", v_reset, 20'hFFFFF);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 2'(i + 1), 1'(i & 1));
    for (int i = 0; i < 5; i++)  step(1'b0, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 2'(3 - (i & 3)), 1'b1);

    // Reset mid-run after 50 free cycles
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 2'(i), 1'(i % 3 == 0));
    step(1'b1, 1'b1, 2'd3, 1'b1); push("reset_midrun", v_reset, 20'hFFFFF);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
